// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for the ring sequencer / frequency meter.
// The helper sizes a down-counter that must hold the values 0..n-1.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_GATE_CYCLES   = 1024;
  localparam int unsigned DEF_STALL_CYCLES  = 64;

  function automatic int unsigned ctr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/la_sync_edge.sv
// Brings the asynchronous ring handshake into the clk domain through a 2-flop
// synchronizer and flags each rising edge for one cycle.
module la_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic la_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       lvl_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], la_i};
      lvl_q  <= sync_q[1];
    end
  end

  // Only settled stages feed the edge decision; sync_q[0] may still be metastable.
  assign rise_o = sync_q[1] & ~lvl_q;

endmodule

// File: rtl/ring_meas_ctrl.sv
// Holds the self-timed ring in reset, releases it, waits a settle interval and
// counts la rising edges over a fixed clk gate window, with stall detection.
module ring_meas_ctrl
  import ring_meas_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned STALL_CYCLES  = DEF_STALL_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             la,
  output logic             ring_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             stalled,
  output logic             overflow
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TMR_W   = ctr_w(TMR_MAX);
  localparam int unsigned STL_W   = ctr_w(STALL_CYCLES);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [STL_W-1:0] STALL_LIM = STL_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [STL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stalled_q, stalled_d;
  logic             overflow_q, overflow_d;
  logic             ring_rst_q, busy_q, done_q;
  logic             la_rise;

  la_sync_edge u_la_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .la_i   (la),
    .rise_o (la_rise)
  );

  // NOTE: every signal driven here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    stall_d    = stall_q;
    count_d    = count_q;
    stalled_d  = stalled_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          tmr_d      = SETTLE_LD;
          count_d    = '0;
          stalled_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end

      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = GATE_LD;
          stall_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      GATE: begin
        if (la_rise) begin
          stall_d = '0;
          if (count_q == CNT_MAX) overflow_d = 1'b1;
          else                    count_d    = count_q + 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end

        // Gate expiry takes priority over a stall hitting in the same cycle.
        if (tmr_q == '0) begin
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (!la_rise && stall_q == STALL_LIM) begin
            state_d   = REPORT;
            stalled_d = 1'b1;
          end
        end
      end

      REPORT: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      stall_q    <= '0;
      count_q    <= '0;
      stalled_q  <= 1'b0;
      overflow_q <= 1'b0;
      ring_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      stall_q    <= stall_d;
      count_q    <= count_d;
      stalled_q  <= stalled_d;
      overflow_q <= overflow_d;
      ring_rst_q <= (state_d == IDLE) || (state_d == REPORT);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == REPORT);
    end
  end

  assign ring_rst = ring_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign stalled  = stalled_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_meas_ctrl.sv
// Self-checking bench for ring_meas_ctrl: table of measurement scenarios plus
// hand-written reset, overflow, ignore, abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_ring_meas_ctrl;

  logic        clk, rst, start, la;
  logic        ring_rst, busy, done, stalled, overflow;
  logic [15:0] count;

  logic        start_b, la_b;
  logic        ring_rst_b, busy_b, done_b, stalled_b, overflow_b;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int la_half = 0;
  bit prev_done = 1'b0;

  typedef struct {
    int cnt_lo;
    int cnt_hi;
    bit stl;
    bit ovf;
    int done_cyc;
  } exp_t;

  typedef struct {
    int half_ns;
    int cnt_lo;
    int cnt_hi;
    bit stl;
    int lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  ring_meas_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .la       (la),
    .ring_rst (ring_rst),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .stalled  (stalled),
    .overflow (overflow)
  );

  ring_meas_ctrl #(.CNT_W(4)) u_dut_ovf (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .la       (la_b),
    .ring_rst (ring_rst_b),
    .busy     (busy_b),
    .done     (done_b),
    .count    (count_b),
    .stalled  (stalled_b),
    .overflow (overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // la toggles off the clock grid; la_half = 0 parks it low.
  initial begin
    la = 1'b0;
    #2;
    forever begin
      if (la_half > 0) begin
        #(la_half);
        la = ~la;
      end else begin
        la = 1'b0;
        #1;
      end
    end
  end

  initial begin
    la_b = 1'b0;
    #3;
    forever #20 la_b = ~la_b;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic pulse_start(output int t);
    t = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d results outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_pulse_width", done, 0);
    prev_done = done;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb_q.pop_front();
        check_range("count_at_done", count, e.cnt_lo, e.cnt_hi);
        check("stalled_at_done", stalled, e.stl);
        check("overflow_at_done", overflow, e.ovf);
        check("done_cycle", cyc, e.done_cyc);
        check("ring_rst_at_done", ring_rst, 1);
        check("busy_at_done", busy, 1);
      end
    end
  end

  initial begin
    int t;
    int n;

    vecs[0] = '{half_ns: 40, cnt_lo: 127, cnt_hi: 129, stl: 1'b0, lat: 1041};
    vecs[1] = '{half_ns: 0,  cnt_lo: 0,   cnt_hi: 0,   stl: 1'b1, lat: 81};
    vecs[2] = '{half_ns: 20, cnt_lo: 255, cnt_hi: 257, stl: 1'b0, lat: 1041};
    vecs[3] = '{half_ns: 80, cnt_lo: 63,  cnt_hi: 65,  stl: 1'b0, lat: 1041};
    vecs[4] = '{half_ns: 40, cnt_lo: 127, cnt_hi: 129, stl: 1'b0, lat: 1041};

    // Reset with start asserted and la toggling: start must be ignored.
    rst = 1'b0; start = 1'b1; start_b = 1'b0; la_half = 40;
    tick();
    tick();
    check("rst_ring_rst", ring_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_stalled", stalled, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ring_rst_b", ring_rst_b, 1);
    start = 1'b0; rst = 1'b1;
    tick();
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_ring_rst", ring_rst, 1);

    // Table-driven measurements.
    for (int i = 0; i < 5; i++) begin
      la_half = vecs[i].half_ns;
      repeat (20) tick();
      check("pre_start_ring_rst", ring_rst, 1);
      sb_q.push_back('{cnt_lo: vecs[i].cnt_lo, cnt_hi: vecs[i].cnt_hi,
                       stl: vecs[i].stl, ovf: 1'b0, done_cyc: cyc + vecs[i].lat});
      pulse_start(t);
      check("release_ring_rst", ring_rst, 0);
      check("release_busy", busy, 1);
      wait_sb_empty($sformatf("meas_vec%0d", i), 1200);
      repeat (2) tick();
      check("idle_after_report", busy, 0);
      check("ring_rst_after_report", ring_rst, 1);
    end

    // Saturation on the 4-bit instance with a 40 ns la period.
    t = cyc;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 1200) begin
      tick();
      n++;
    end
    check("ovf_done_seen", done_b, 1);
    check("ovf_done_cycle", cyc, t + 1041);
    check("ovf_count", count_b, 15);
    check("ovf_overflow", overflow_b, 1);
    check("ovf_stalled", stalled_b, 0);

    // start pulsed mid-gate is ignored and not queued.
    la_half = 40;
    repeat (20) tick();
    sb_q.push_back('{cnt_lo: 127, cnt_hi: 129, stl: 1'b0, ovf: 1'b0, done_cyc: cyc + 1041});
    pulse_start(t);
    wait_cyc(t + 1 + 16 + 300);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_still_busy", busy, 1);
    wait_sb_empty("ignore_meas", 1200);
    repeat (5) tick();
    check("start_not_queued", busy, 0);

    // Abort at gate cycle 500: no done, everything back to reset values.
    pulse_start(t);
    wait_cyc(t + 1 + 16 + 500);
    check_range("abort_count_mid_gate", count, 58, 67);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_ring_rst", ring_rst, 1);
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_done", done, 0);
    check("abort_stalled", stalled, 0);
    repeat (1100) tick();
    check("abort_stays_idle", busy, 0);

    // Back-to-back with start held high: done every 1042 cycles.
    repeat (20) tick();
    t = cyc;
    sb_q.push_back('{cnt_lo: 127, cnt_hi: 129, stl: 1'b0, ovf: 1'b0, done_cyc: t + 1041});
    sb_q.push_back('{cnt_lo: 127, cnt_hi: 129, stl: 1'b0, ovf: 1'b0, done_cyc: t + 2083});
    sb_q.push_back('{cnt_lo: 127, cnt_hi: 129, stl: 1'b0, ovf: 1'b0, done_cyc: t + 3125});
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_cyc(t + 1041 + 1042 * k + 1);
      check("b2b_idle_busy", busy, 0);
      check_range("b2b_count_held", count, 127, 129);
      tick();
      check("b2b_count_cleared", count, 0);
      check("b2b_restart_busy", busy, 1);
    end
    start = 1'b0;
    wait_sb_empty("b2b_meas", 1200);
    repeat (3) tick();
    check("b2b_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_meas_ctrl.md
# ring_meas_ctrl

Synchronous sequencer and frequency meter for the self-timed 4-stage ring. It holds the ring in reset, releases it on request, and waits a settle interval. It then counts rising edges of the ring's `la` handshake over a fixed gate window of `clk` cycles and reports the count with a done pulse. It replaces the simulation-only cycle-time measurement with hardware usable on silicon and in gate-level simulation.

## Interface
- `CNT_W`, 16: edge-count width.
- `SETTLE_CYCLES`, 16: clk cycles between ring release and gate open; ≥1.
- `GATE_CYCLES`, 1024: gate window length in clk cycles; ≥1.
- `STALL_CYCLES`, 64: clk cycles without an `la` edge during gate that declare the ring stalled; ≥4.
- `clk` in 1: measurement clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: request a measurement; sampled only in IDLE.
- `la` in 1: asynchronous ring output; must toggle slower than clk/2 for an exact count.
- `ring_rst` out 1: active-high reset to the ring.
- `busy` out 1: high in SETTLE, GATE and REPORT.
- `done` out 1: one-cycle pulse in REPORT.
- `count` out CNT_W: rising-edge count from the last gate window.
- `stalled` out 1: last measurement ended on stall timeout.
- `overflow` out 1: `count` saturated in the last measurement.

## Operation
- Reset values: `ring_rst`=1, `busy`=0, `done`=0, `count`=0, `stalled`=0, `overflow`=0, state IDLE, synchronizer flops 0.
- IDLE: `ring_rst`=1. `start`=1 moves to SETTLE. On that same edge the block clears `count`, `stalled` and `overflow`, and loads the settle counter.
- SETTLE: `ring_rst`=0. The block counts SETTLE_CYCLES cycles, then moves to GATE. The synchronizer and edge detector run, but edges are not counted.
- GATE: `ring_rst`=0.
  - Each detected rising edge increments `count`.
  - `count` saturates at 2^CNT_W−1. An edge arriving while saturated sets `overflow`.
  - The gate counter runs GATE_CYCLES cycles.
  - The stall counter clears on gate entry and on every detected edge. When it reaches STALL_CYCLES, the block sets `stalled` and moves to REPORT early.
  - If the gate counter expires, the block moves to REPORT.
  - If the gate expires and the stall limit is reached in the same cycle, the gate expiry wins and `stalled` stays 0.
  - If STALL_CYCLES ≥ GATE_CYCLES, a stall can never be flagged.
- REPORT, one cycle: `done`=1 and `ring_rst`=1. An edge detected in this cycle is not counted. Next state is IDLE.
- `count`, `stalled` and `overflow` hold from REPORT until the next accepted `start`.
- `start` outside IDLE is ignored. It is not queued.
- If `start` is held high, a new measurement starts one cycle after each REPORT, because IDLE lasts one cycle.
- `rst`=0 in any state: on the next edge the block is in IDLE with all outputs at reset values. No `done` is produced for an aborted measurement.

## Timing
- Edge detection: `la` passes through a 2-flop synchronizer, then an edge register. A rising edge of `la` is counted 3 clk edges later, which adds ±1 count of quantization at each end of the window.
- `start` sampled high at edge t:
  - SETTLE starts at t+1 and `ring_rst` falls at t+1.
  - GATE runs from t+1+SETTLE_CYCLES for GATE_CYCLES cycles.
  - `done` is high at t+1+SETTLE_CYCLES+GATE_CYCLES.
  - IDLE is reached one cycle later.
- Stall path: `done` is high at t+1+SETTLE_CYCLES+STALL_CYCLES when no edge occurs.
- All outputs are registered. `count` is stable whenever `done`=1.
- Expected count is GATE_CYCLES × T_clk / T_la.

## Structure
- Package `ring_meas_pkg`:
  - state enum {IDLE, SETTLE, GATE, REPORT};
  - default constants for CNT_W, SETTLE_CYCLES, GATE_CYCLES and STALL_CYCLES;
  - counter-width helper based on $clog2.
- Sub-module `la_sync_edge`: 2-flop synchronizer plus registered rising-edge pulse, with reset to 0.
- Top level holds the FSM, a shared settle/gate down-counter, the stall counter and the saturating edge counter.

## Test plan
- Reset: `rst`=0 for 2 cycles with `la` toggling → `ring_rst`=1, all other outputs 0, `start` ignored during reset.
- Nominal: clk 10 ns, `la` period 80 ns, defaults → `count`=128±1, `stalled`=0, `overflow`=0, `done` one cycle at t+1041.
- Stall: `la` stuck low after release → `stalled`=1, `count`=0, `done` at t+81, `ring_rst`=1 from that cycle.
- Overflow: CNT_W=4, `la` period 40 ns → `count`=15, `overflow`=1.
- Abort and ignore: `start` pulsed mid-GATE is ignored. `rst`=0 at gate cycle 500 → IDLE next cycle, `ring_rst`=1, `count`=0, no `done`.
- Back-to-back: `start` held high with a stable 80 ns `la` → `done` every 1042 cycles, `count` cleared then re-reaching 128±1 each time.
